cdf_accumulator: RTL
====================

# cdf_accumulator

Upstream stage of the histogram-equalisation pipeline. It accepts one histogram bin count per transfer and keeps a running cumulative sum (CDF). For each bin it presents an 8-bit scaled CDF value to the divider stage with a one-cycle `enable` pulse. It then waits for the divider's `ready_g_out` before taking the next bin. One frame is NUM_BINS bins, ending with a `done` pulse.

## Interface
- NUM_BINS, 256: bins per frame; power of two, at most 256.
- CNT_W, 16: width of one bin count.
- SUM_W, CNT_W+8: width of the running sum; wide enough that it never overflows.
- SHIFT, 8: right shift that scales the sum to an 8-bit CDF.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; the port is named `reset` but is active when 0.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- hist_in  in  CNT_W  count for the current bin.
- hist_valid  in  1  hist_in is valid.
- hist_ready  out  1  high in LOAD; a transfer happens when hist_valid and hist_ready are both high.
- cdf_out  out  8  scaled CDF; drives divider `cdf_in`.
- enable_out  out  1  one-cycle pulse; drives divider `enable`.
- ready_g_in  in  1  from divider `ready_g_out`; level signal.
- bin_idx  out  8  index of the bin in flight.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a frame.
- total_out  out  SUM_W  final sum; valid from the DONE cycle and held until the next start.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE:
  - start clears sum, bin_idx and min_reg, then moves to LOAD.
  - start is ignored in every other state.
- LOAD:
  - hist_ready = 1.
  - On a transfer: sum <= sum + hist_in, then move to ISSUE.
  - With no hist_valid, stay in LOAD indefinitely.
- ISSUE:
  - enable_out = 1 for exactly this cycle.
  - cdf_out is registered and valid from this cycle.
  - Next state is WAIT.
- WAIT:
  - cdf_out is held.
  - The state advances on a rising edge of ready_g_in: ready_g_in=1 and the registered previous value = 0.
  - If bin_idx = NUM_BINS-1, go to DONE; otherwise bin_idx++ and go to LOAD.
  - A ready_g_in edge that arrives in any other state is ignored, and the edge detector still updates.
- DONE: done = 1 and total_out <= sum, then move to IDLE.
- Scaling: v = sum >> SHIFT. cdf_out = v[7:0] if v < 256, otherwise 255 (saturate).
- Reset values: state IDLE; hist_ready, enable_out, busy and done = 0; cdf_out, bin_idx, total_out, sum and min_reg = 0.
- Reset asserted mid-frame: all outputs go to their reset values immediately and asynchronously. The partial frame is discarded and nothing resumes after reset is released.

## Timing
- hist transfer at cycle N gives enable_out = 1 and a valid cdf_out at cycle N+1.
- A ready_g_in rising edge sampled at cycle M gives hist_ready = 1 at M+1 (LOAD), or done = 1 at M+1 (last bin).
- Minimum bin period is 3 cycles (LOAD, ISSUE, WAIT) plus the divider latency.
- done is never asserted in the same cycle as enable_out.
- busy falls in the cycle after done.

## Configuration
- Macro `CDF_MIN_SUBTRACT_EN`.
  - Defined:
    - min_reg latches the first non-zero sum of the frame.
    - Scaling uses (sum − min_reg) for every bin from that point on.
    - Bins before the first non-zero sum output 0.
  - Undefined: min_reg is absent and scaling uses the raw sum.

## Test plan
- Basic frame, macro undefined, SHIFT=0, hist_in=1 for every bin, divider model sends a ready edge 4 cycles after each enable. Required: cdf_out = k+1 for bins k = 0..253, 255 for bins 254 and 255; exactly 256 enable pulses; one done pulse; total_out = 256.
- Single spike, SHIFT=8, bin 128 = 1000, all other bins 0. Required: cdf_out = 0 for bins 0..127 and 3 for bins 128..255.
- Macro defined, SHIFT=0, hist_in=1 for every bin. Required: min_reg = 1 and cdf_out = k for bin k, saturating to 255 only above 255.
- Handshake robustness:
  - Hold ready_g_in high continuously. Required: exactly one advance per low-to-high edge; no double advance.
  - Stall hist_valid low for 10 cycles in LOAD. Required: state held and no enable pulse.
- Reset taken low in WAIT at bin 37. Required: outputs are 0 in the same cycle. After reset is released, start gives a fresh frame beginning at bin_idx 0 with sum 0.
- start asserted while busy. Required: ignored, with bin_idx and sum unchanged.

Source files
------------

// File: rtl/cdf_accumulator.sv
// Running-sum CDF stage: takes one histogram bin per transfer and hands an 8-bit scaled CDF to the divider.
// Optional feature macro: CDF_MIN_SUBTRACT_EN (subtract the first non-zero sum of the frame before scaling).
module cdf_accumulator #(
    parameter int NUM_BINS = 256,
    parameter int CNT_W    = 16,
    parameter int SUM_W    = CNT_W + 8,
    parameter int SHIFT    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] hist_in,
    input  logic             hist_valid,
    output logic             hist_ready,
    output logic [7:0]       cdf_out,
    output logic             enable_out,
    input  logic             ready_g_in,
    output logic [7:0]       bin_idx,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] total_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_BIN = 8'(NUM_BINS - 1);

    state_t           state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] total_q, total_d;
    logic [7:0]       bin_q, bin_d;
    logic [7:0]       cdf_q, cdf_d;
    logic             hist_ready_q, hist_ready_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_prev_q;
    logic             ready_rise;
`ifdef CDF_MIN_SUBTRACT_EN
    logic [SUM_W-1:0] min_q, min_d;
`endif

    function automatic logic [7:0] scale_sat(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] v;
        v = s >> SHIFT;
        if (|(v >> 8)) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        total_d      = total_q;
        bin_d        = bin_q;
        cdf_d        = cdf_q;
        hist_ready_d = 1'b0;
        enable_d     = 1'b0;
        busy_d       = 1'b1;
        done_d       = 1'b0;
        ready_rise   = ready_g_in & ~ready_prev_q;
`ifdef CDF_MIN_SUBTRACT_EN
        min_d        = min_q;
`endif

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d      = S_LOAD;
                    sum_d        = '0;
                    bin_d        = '0;
`ifdef CDF_MIN_SUBTRACT_EN
                    min_d        = '0;
`endif
                    hist_ready_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            S_LOAD: begin
                hist_ready_d = 1'b1;
                if (hist_valid && hist_ready_q) begin
                    sum_d = sum_q + SUM_W'(hist_in);
`ifdef CDF_MIN_SUBTRACT_EN
                    // min_q stays zero until the sum first becomes non-zero, then freezes
                    if (min_q == '0) begin
                        min_d = sum_d;
                    end
                    cdf_d = scale_sat(sum_d - min_d);
`else
                    cdf_d = scale_sat(sum_d);
`endif
                    hist_ready_d = 1'b0;
                    enable_d     = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ready_rise) begin
                    if (bin_q == LAST_BIN) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        total_d = sum_q;
                    end else begin
                        bin_d        = bin_q + 8'd1;
                        state_d      = S_LOAD;
                        hist_ready_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sum_q        <= '0;
            total_q      <= '0;
            bin_q        <= '0;
            cdf_q        <= '0;
            hist_ready_q <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_prev_q <= 1'b0;
`ifdef CDF_MIN_SUBTRACT_EN
            min_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            total_q      <= total_d;
            bin_q        <= bin_d;
            cdf_q        <= cdf_d;
            hist_ready_q <= hist_ready_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            // edge detector tracks ready_g_in in every state
            ready_prev_q <= ready_g_in;
`ifdef CDF_MIN_SUBTRACT_EN
            min_q        <= min_d;
`endif
        end
    end

    assign hist_ready = hist_ready_q;
    assign enable_out = enable_q;
    assign cdf_out    = cdf_q;
    assign bin_idx    = bin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign total_out  = total_q;

endmodule
